mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous, active-low: `rst  in  1  reset (0 = reset)`; `clk  in  1  clock, rising edge`.
REQ-002 Fetch-side ports SHALL be:
- `imem_valid  in  1` request pulse
- `imem_addr  in  32` word address
- `imem_flush  in  1` cancel fetch
- `imem_ready  out  1` completion pulse
- `imem_rdata  out  32` fetched word
REQ-003 Data-side ports SHALL be:
- `dmem_valid  in  1` request pulse
- `dmem_addr  in  32` address
- `dmem_wdata  in  32` store data
- `dmem_wstrb  in  4` byte strobes; 0 = load
- `dmem_ready  out  1` completion pulse
- `dmem_rdata  out  32` load data
REQ-004 Shared-bus ports SHALL be:
- `bus_valid  out  1` request
- `bus_instr  out  1` 1 = fetch
- `bus_addr  out  32`
- `bus_wdata  out  32`
- `bus_wstrb  out  4`
- `bus_ready  in  1` completion
- `bus_rdata  in  32` read data

Function
REQ-005 The block SHALL hold one pending slot per side (addr, wdata, wstrb, flag), loaded on the rising edge where the side's valid = 1.
REQ-006 A requester SHALL NOT re-assert valid until its ready pulse; the bench SHALL flag violations.
REQ-007 FSM states SHALL be IDLE, IBUSY, DBUSY.
REQ-008 IDLE SHALL grant only slots already pending. A valid arriving in IDLE SHALL be captured that cycle and granted on the next cycle.
REQ-009 Without the macro, the data slot SHALL have fixed priority over fetch when both are pending.
REQ-010 On grant, the FSM SHALL enter IBUSY or DBUSY and clear that slot. bus_valid, bus_instr, bus_addr, bus_wdata and bus_wstrb SHALL be registered and stable while busy.
REQ-011 In a busy state with bus_ready = 1:
- bus_valid SHALL drop next cycle.
- The FSM SHALL return to IDLE.
- The matching ready SHALL pulse high for exactly one cycle, the cycle after bus_ready.
- The matching rdata SHALL be a registered copy of bus_rdata.
REQ-012 Latency: valid at cycle t with the bus idle gives bus_valid at t+1. bus_ready at t+k gives ready at t+k+1. The next grant is at earliest t+k+1.
REQ-013 On a store (wstrb ≠ 0), dmem_rdata SHALL hold its previous value and dmem_ready SHALL still pulse.
REQ-014 imem_flush = 1 SHALL:
- clear the pending fetch slot;
- if in IBUSY, mark the in-flight fetch killed, so it completes on the bus but imem_ready stays 0.
REQ-015 imem_flush and imem_valid in the same cycle: flush applies to older state, and the new request SHALL be captured.
REQ-016 Flush SHALL NOT affect the data side.
REQ-017 Outside their one-cycle pulse, imem_ready and dmem_ready SHALL be 0.

Reset
REQ-018 While rst = 0, the block SHALL asynchronously force:
- state = IDLE
- pending flags, killed flag and last-grant = 0
- bus_valid, bus_instr, imem_ready, dmem_ready = 0
- bus_addr, bus_wdata, bus_wstrb, imem_rdata, dmem_rdata = 0
REQ-019 Reset mid-transaction SHALL drop the transaction with no ready pulse after reset release.

Configuration
REQ-020 With `MEM_ARBITER_FAIR_EN` defined, simultaneous pending fetch and data SHALL grant the side not granted last (round-robin via a last-grant register, reset value = fetch). A lone pending side SHALL always be granted.
REQ-021 Without `MEM_ARBITER_FAIR_EN`, REQ-009 fixed data priority SHALL apply and no last-grant register SHALL exist.

Verification
REQ-022 Single fetch: imem_valid with addr 0x100, bus_ready 2 cycles after bus_valid, bus_rdata 0x00000013 -> bus_instr = 1, bus_addr = 0x100, imem_ready one cycle later with imem_rdata = 0x00000013.
REQ-023 Contention: imem_valid and dmem_valid in the same cycle (load, addr 0x2000) ->
- Default build: data granted first, fetch granted on the cycle after dmem's bus_ready.
- `MEM_ARBITER_FAIR_EN` build: a second contention round alternates the winner.
REQ-024 Store: dmem_wstrb = 0xF, wdata = 0xDEADBEEF, addr 0x2004 -> bus_wstrb = 0xF, bus_wdata = 0xDEADBEEF, dmem_ready pulses, dmem_rdata unchanged.
REQ-025 Flush in flight: fetch in IBUSY, imem_flush = 1, then bus_ready -> no imem_ready. A new imem_valid at 0x200 in the flush cycle completes normally.
REQ-026 Async reset: rst dropped low mid-DBUSY, between clock edges -> bus_valid = 0 immediately. After release, no dmem_ready occurs and the FSM is IDLE.
REQ-027 Back-to-back: 8 alternating fetch/load requests with bus_ready = 1 on the first busy cycle -> each ready pulse exactly one cycle, with no lost or duplicated responses.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-side, data-side and shared-bus signals around mem_arbiter.
// slave  : the arbiter's view (takes requests, drives the shared bus).
// master : the surrounding system's view (issues requests, answers the bus).
interface mem_arbiter_if;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_flush;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  logic        bus_valid;
  logic        bus_instr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport slave (
    input  imem_valid, imem_addr, imem_flush,
    output imem_ready, imem_rdata,
    input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rdata,
    output bus_valid, bus_instr, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata
  );

  modport master (
    output imem_valid, imem_addr, imem_flush,
    input  imem_ready, imem_rdata,
    output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rdata,
    input  bus_valid, bus_instr, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between an instruction-fetch port and a
// load/store port. Each side owns a single pending slot; an IDLE/IBUSY/DBUSY
// FSM grants one slot at a time and returns a one-cycle ready pulse.
// Optional build macro MEM_ARBITER_FAIR_EN: round-robin between the two sides
// on contention; without it the data side always wins a tie.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  arb
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IBUSY = 2'd1;
  localparam logic [1:0] DBUSY = 2'd2;

  logic [1:0]  r_state;

  logic        r_ipend;
  logic [31:0] r_iaddr;
  logic        r_dpend;
  logic [31:0] r_daddr;
  logic [31:0] r_dwdata;
  logic [3:0]  r_dwstrb;

  logic        r_killed;

  logic        r_bus_valid;
  logic        r_bus_instr;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_wstrb;

  logic        r_iready;
  logic [31:0] r_irdata;
  logic        r_dready;
  logic [31:0] r_drdata;

  logic        w_ipend_live;
  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_idone;
  logic        w_ddone;

  // A flush in the same cycle cancels the fetch that was already waiting.
  assign w_ipend_live = r_ipend & ~arb.imem_flush;

`ifdef MEM_ARBITER_FAIR_EN
  // 1 = data side won the most recent contested arbitration.
  logic r_last_data;

  assign w_grant_d = (r_state == IDLE) & r_dpend & (~w_ipend_live | ~r_last_data);
`else
  assign w_grant_d = (r_state == IDLE) & r_dpend;
`endif
  assign w_grant_i = (r_state == IDLE) & w_ipend_live & ~w_grant_d;

  assign w_idone = (r_state == IBUSY) & arb.bus_ready;
  assign w_ddone = (r_state == DBUSY) & arb.bus_ready;

`ifdef MEM_ARBITER_FAIR_EN
  // Remember who won a tie so the next tie goes the other way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_data <= 1'b0;
    end else if (w_grant_d && w_ipend_live) begin
      r_last_data <= 1'b1;
    end else if (w_grant_i && r_dpend) begin
      r_last_data <= 1'b0;
    end
  end
`endif

  // Pending-slot flags: set on a request, cleared by grant (or flush for fetch).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ipend <= 1'b0;
      r_dpend <= 1'b0;
    end else begin
      if (arb.imem_valid) begin
        r_ipend <= 1'b1;
      end else if (arb.imem_flush || w_grant_i) begin
        r_ipend <= 1'b0;
      end
      if (arb.dmem_valid) begin
        r_dpend <= 1'b1;
      end else if (w_grant_d) begin
        r_dpend <= 1'b0;
      end
    end
  end

  // Pending-slot payload is only meaningful while its flag is set.
  always_ff @(posedge clk) begin
    if (arb.imem_valid) begin
      r_iaddr <= arb.imem_addr;
    end
    if (arb.dmem_valid) begin
      r_daddr  <= arb.dmem_addr;
      r_dwdata <= arb.dmem_wdata;
      r_dwstrb <= arb.dmem_wstrb;
    end
  end

  // Grant FSM; the bus request is registered and held until bus_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bus_valid <= 1'b0;
      r_bus_instr <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_wstrb <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= DBUSY;
            r_bus_valid <= 1'b1;
            r_bus_instr <= 1'b0;
            r_bus_addr  <= r_daddr;
            r_bus_wdata <= r_dwdata;
            r_bus_wstrb <= r_dwstrb;
          end else if (w_grant_i) begin
            r_state     <= IBUSY;
            r_bus_valid <= 1'b1;
            r_bus_instr <= 1'b1;
            r_bus_addr  <= r_iaddr;
            r_bus_wdata <= 32'd0;
            r_bus_wstrb <= 4'd0;
          end
        end
        IBUSY, DBUSY: begin
          if (arb.bus_ready) begin
            r_state     <= IDLE;
            r_bus_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_bus_valid <= 1'b0;
        end
      endcase
    end
  end

  // Killed flag: a flushed in-flight fetch still finishes on the bus silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_killed <= 1'b0;
    end else if (w_grant_i) begin
      r_killed <= 1'b0;
    end else if ((r_state == IBUSY) && arb.imem_flush) begin
      r_killed <= 1'b1;
    end
  end

  // Response side: one-cycle ready pulses and registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iready <= 1'b0;
      r_irdata <= 32'd0;
      r_dready <= 1'b0;
      r_drdata <= 32'd0;
    end else begin
      r_iready <= w_idone & ~r_killed & ~arb.imem_flush;
      r_dready <= w_ddone;
      if (w_idone && !r_killed && !arb.imem_flush) begin
        r_irdata <= arb.bus_rdata;
      end
      if (w_ddone && (r_bus_wstrb == 4'd0)) begin
        r_drdata <= arb.bus_rdata;
      end
    end
  end

  assign arb.bus_valid  = r_bus_valid;
  assign arb.bus_instr  = r_bus_instr;
  assign arb.bus_addr   = r_bus_addr;
  assign arb.bus_wdata  = r_bus_wdata;
  assign arb.bus_wstrb  = r_bus_wstrb;
  assign arb.imem_ready = r_iready;
  assign arb.imem_rdata = r_irdata;
  assign arb.dmem_ready = r_dready;
  assign arb.dmem_rdata = r_drdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: a bus responder with programmable
// latency, monitors that log grants and ready pulses, and one task per scenario.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_arbiter_if u_if ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .arb (u_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 0;
  int rcnt  = 0;

  logic        g_instr [64];
  logic [31:0] g_addr  [64];
  logic [31:0] g_wdata [64];
  logic [3:0]  g_wstrb [64];
  int          g_cyc   [64];
  int          g_n = 0;
  logic [31:0] i_data  [64];
  int          i_cyc   [64];
  int          i_n = 0;
  logic [31:0] d_data  [64];
  int          d_cyc   [64];
  int          d_n = 0;

  logic        p_bv = 1'b0;
  logic        p_instr;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;
  int          stab_err = 0;
  int          viol = 0;
  logic        i_out = 1'b0;
  logic        d_out = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'hA5A5_0000) + 32'h11);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory side: answer a bus request after 'lat' extra busy cycles.
  always @(posedge clk) begin
    #1;
    if (u_if.bus_ready || !u_if.bus_valid) begin
      u_if.bus_ready = 1'b0;
      rcnt = 0;
    end else if (rcnt >= lat) begin
      u_if.bus_ready = 1'b1;
      u_if.bus_rdata = mem_rd(u_if.bus_addr);
      rcnt = 0;
    end else begin
      rcnt++;
    end
  end

  // Log each new grant, bus stability while busy, and every ready-high cycle.
  always @(posedge clk) begin
    #1;
    if (u_if.bus_valid && !p_bv && g_n < 64) begin
      g_instr[g_n] = u_if.bus_instr;
      g_addr[g_n]  = u_if.bus_addr;
      g_wdata[g_n] = u_if.bus_wdata;
      g_wstrb[g_n] = u_if.bus_wstrb;
      g_cyc[g_n]   = cyc;
      g_n++;
    end
    if (u_if.bus_valid && p_bv &&
        ({u_if.bus_instr, u_if.bus_addr, u_if.bus_wdata, u_if.bus_wstrb} !== {p_instr, p_addr, p_wdata, p_wstrb}))
      stab_err++;
    p_bv    = u_if.bus_valid;
    p_instr = u_if.bus_instr;
    p_addr  = u_if.bus_addr;
    p_wdata = u_if.bus_wdata;
    p_wstrb = u_if.bus_wstrb;
    if (u_if.imem_ready && i_n < 64) begin
      i_data[i_n] = u_if.imem_rdata;
      i_cyc[i_n]  = cyc;
      i_n++;
    end
    if (u_if.dmem_ready && d_n < 64) begin
      d_data[d_n] = u_if.dmem_rdata;
      d_cyc[d_n]  = cyc;
      d_n++;
    end
  end

  // Requester protocol: no new valid on a side until its ready (or a flush).
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_out = 1'b0;
      d_out = 1'b0;
    end else begin
      if (u_if.imem_ready || u_if.imem_flush) i_out = 1'b0;
      if (u_if.imem_valid) begin
        if (i_out) viol++;
        i_out = 1'b1;
      end
      if (u_if.dmem_ready) d_out = 1'b0;
      if (u_if.dmem_valid) begin
        if (d_out) viol++;
        d_out = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int quiet;
    quiet = 0;
    for (int n = 0; n < budget && quiet < 3; n++) begin
      step();
      if (!u_if.bus_valid && !u_if.imem_ready && !u_if.dmem_ready && !u_if.imem_valid && !u_if.dmem_valid)
        quiet++;
      else
        quiet = 0;
    end
    if (quiet < 3) begin
      total++; bad++;
      $display("FAIL idle_timeout got=busy required=idle within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    u_if.imem_valid = 0; u_if.imem_addr = 0; u_if.imem_flush = 0;
    u_if.dmem_valid = 0; u_if.dmem_addr = 0; u_if.dmem_wdata = 0; u_if.dmem_wstrb = 0;
    u_if.bus_ready = 0; u_if.bus_rdata = 0;
    rst = 1'b0;
    step(); step();
    total++; if ({u_if.bus_valid, u_if.bus_instr, u_if.imem_ready, u_if.dmem_ready} !== 4'b0) begin bad++; $display("FAIL rst_ctrl got=%b required=0000", {u_if.bus_valid, u_if.bus_instr, u_if.imem_ready, u_if.dmem_ready}); end
    total++; if (u_if.bus_addr !== 32'd0) begin bad++; $display("FAIL rst_bus_addr got=%h required=0", u_if.bus_addr); end
    total++; if (u_if.bus_wdata !== 32'd0) begin bad++; $display("FAIL rst_bus_wdata got=%h required=0", u_if.bus_wdata); end
    total++; if (u_if.bus_wstrb !== 4'd0) begin bad++; $display("FAIL rst_bus_wstrb got=%h required=0", u_if.bus_wstrb); end
    total++; if (u_if.imem_rdata !== 32'd0) begin bad++; $display("FAIL rst_imem_rdata got=%h required=0", u_if.imem_rdata); end
    total++; if (u_if.dmem_rdata !== 32'd0) begin bad++; $display("FAIL rst_dmem_rdata got=%h required=0", u_if.dmem_rdata); end
    rst = 1'b1;
    step(); step(); step();
    total++; if ({u_if.bus_valid, u_if.imem_ready, u_if.dmem_ready} !== 3'b0) begin bad++; $display("FAIL post_rst_idle got=%b required=000", {u_if.bus_valid, u_if.imem_ready, u_if.dmem_ready}); end
    total++; if (g_n !== 0) begin bad++; $display("FAIL post_rst_grants got=%0d required=0", g_n); end
  endtask

  task automatic test_single_fetch();
    int k, g0, i0;
    lat = 2; g0 = g_n; i0 = i_n; k = cyc;
    u_if.imem_valid = 1; u_if.imem_addr = 32'h100;
    step();
    u_if.imem_valid = 0;
    wait_idle(50);
    total++; if (g_n - g0 !== 1) begin bad++; $display("FAIL fetch_grants got=%0d required=1", g_n - g0); end
    total++; if (g_instr[g0] !== 1'b1) begin bad++; $display("FAIL fetch_bus_instr got=%b required=1", g_instr[g0]); end
    total++; if (g_addr[g0] !== 32'h100) begin bad++; $display("FAIL fetch_bus_addr got=%h required=00000100", g_addr[g0]); end
    total++; if (g_cyc[g0] !== k + 2) begin bad++; $display("FAIL fetch_grant_cycle got=%0d required=%0d", g_cyc[g0], k + 2); end
    total++; if (i_n - i0 !== 1) begin bad++; $display("FAIL fetch_ready_cycles got=%0d required=1", i_n - i0); end
    total++; if (i_data[i0] !== 32'h0000_0013) begin bad++; $display("FAIL fetch_rdata got=%h required=00000013", i_data[i0]); end
    total++; if (i_cyc[i0] !== k + 5) begin bad++; $display("FAIL fetch_ready_cycle got=%0d required=%0d", i_cyc[i0], k + 5); end
  endtask

  task automatic test_contention();
    int k, g0, i0, d0;
    logic first_instr;
    lat = 1; g0 = g_n; i0 = i_n; d0 = d_n; k = cyc;
    u_if.imem_valid = 1; u_if.imem_addr = 32'h300;
    u_if.dmem_valid = 1; u_if.dmem_addr = 32'h2000; u_if.dmem_wstrb = 4'h0; u_if.dmem_wdata = 32'h0;
    step();
    u_if.imem_valid = 0; u_if.dmem_valid = 0;
    wait_idle(50);
    total++; if (g_n - g0 !== 2) begin bad++; $display("FAIL cont1_grants got=%0d required=2", g_n - g0); end
    total++; if ({g_instr[g0], g_addr[g0]} !== {1'b0, 32'h2000}) begin bad++; $display("FAIL cont1_first got=%b/%h required=0/00002000", g_instr[g0], g_addr[g0]); end
    total++; if (g_cyc[g0] !== k + 2) begin bad++; $display("FAIL cont1_first_cycle got=%0d required=%0d", g_cyc[g0], k + 2); end
    total++; if (d_cyc[d0] !== k + 4) begin bad++; $display("FAIL cont1_dready_cycle got=%0d required=%0d", d_cyc[d0], k + 4); end
    total++; if ({g_instr[g0+1], g_addr[g0+1]} !== {1'b1, 32'h300}) begin bad++; $display("FAIL cont1_second got=%b/%h required=1/00000300", g_instr[g0+1], g_addr[g0+1]); end
    total++; if (g_cyc[g0+1] !== k + 5) begin bad++; $display("FAIL cont1_second_cycle got=%0d required=%0d", g_cyc[g0+1], k + 5); end
    total++; if (d_data[d0] !== mem_rd(32'h2000)) begin bad++; $display("FAIL cont1_dmem_rdata got=%h required=%h", d_data[d0], mem_rd(32'h2000)); end
    total++; if (i_data[i0] !== mem_rd(32'h300)) begin bad++; $display("FAIL cont1_imem_rdata got=%h required=%h", i_data[i0], mem_rd(32'h300)); end

`ifdef MEM_ARBITER_FAIR_EN
    first_instr = 1'b1;
`else
    first_instr = 1'b0;
`endif
    g0 = g_n; i0 = i_n; d0 = d_n;
    u_if.imem_valid = 1; u_if.imem_addr = 32'h340;
    u_if.dmem_valid = 1; u_if.dmem_addr = 32'h2008;
    step();
    u_if.imem_valid = 0; u_if.dmem_valid = 0;
    wait_idle(50);
    total++; if (g_n - g0 !== 2) begin bad++; $display("FAIL cont2_grants got=%0d required=2", g_n - g0); end
    total++; if (g_instr[g0] !== first_instr) begin bad++; $display("FAIL cont2_winner got=%b required=%b", g_instr[g0], first_instr); end
    total++; if (g_instr[g0+1] !== !first_instr) begin bad++; $display("FAIL cont2_loser got=%b required=%b", g_instr[g0+1], !first_instr); end
    total++; if (d_data[d0] !== mem_rd(32'h2008)) begin bad++; $display("FAIL cont2_dmem_rdata got=%h required=%h", d_data[d0], mem_rd(32'h2008)); end
    total++; if (i_data[i0] !== mem_rd(32'h340)) begin bad++; $display("FAIL cont2_imem_rdata got=%h required=%h", i_data[i0], mem_rd(32'h340)); end
  endtask

  task automatic test_store();
    int k, g0, d0;
    lat = 0; g0 = g_n; d0 = d_n; k = cyc;
    u_if.dmem_valid = 1; u_if.dmem_addr = 32'h2004; u_if.dmem_wdata = 32'hDEAD_BEEF; u_if.dmem_wstrb = 4'hF;
    step();
    u_if.dmem_valid = 0; u_if.dmem_wstrb = 4'h0; u_if.dmem_wdata = 32'h0;
    wait_idle(50);
    total++; if (g_n - g0 !== 1) begin bad++; $display("FAIL store_grants got=%0d required=1", g_n - g0); end
    total++; if (g_wstrb[g0] !== 4'hF) begin bad++; $display("FAIL store_wstrb got=%h required=f", g_wstrb[g0]); end
    total++; if (g_wdata[g0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_wdata got=%h required=deadbeef", g_wdata[g0]); end
    total++; if ({g_instr[g0], g_addr[g0]} !== {1'b0, 32'h2004}) begin bad++; $display("FAIL store_addr got=%b/%h required=0/00002004", g_instr[g0], g_addr[g0]); end
    total++; if (d_n - d0 !== 1) begin bad++; $display("FAIL store_ready_cycles got=%0d required=1", d_n - d0); end
    total++; if (d_cyc[d0] !== k + 3) begin bad++; $display("FAIL store_ready_cycle got=%0d required=%0d", d_cyc[d0], k + 3); end
    total++; if (d_data[d0] !== mem_rd(32'h2008)) begin bad++; $display("FAIL store_rdata_held got=%h required=%h", d_data[d0], mem_rd(32'h2008)); end
  endtask

  task automatic test_flush();
    int k, g0, i0, d0;
    // Flush while the fetch is in flight, with a new fetch in the same cycle.
    lat = 2; g0 = g_n; i0 = i_n; k = cyc;
    u_if.imem_valid = 1; u_if.imem_addr = 32'h180;
    step();
    u_if.imem_valid = 0;
    step();
    u_if.imem_flush = 1; u_if.imem_valid = 1; u_if.imem_addr = 32'h200;
    step();
    u_if.imem_flush = 0; u_if.imem_valid = 0;
    wait_idle(50);
    total++; if (g_n - g0 !== 2) begin bad++; $display("FAIL flush_grants got=%0d required=2", g_n - g0); end
    total++; if (g_addr[g0] !== 32'h180) begin bad++; $display("FAIL flush_killed_addr got=%h required=00000180", g_addr[g0]); end
    total++; if ({g_instr[g0+1], g_addr[g0+1]} !== {1'b1, 32'h200}) begin bad++; $display("FAIL flush_new_fetch got=%b/%h required=1/00000200", g_instr[g0+1], g_addr[g0+1]); end
    total++; if (g_cyc[g0+1] !== k + 6) begin bad++; $display("FAIL flush_new_grant_cycle got=%0d required=%0d", g_cyc[g0+1], k + 6); end
    total++; if (i_n - i0 !== 1) begin bad++; $display("FAIL flush_ready_count got=%0d required=1", i_n - i0); end
    total++; if (i_data[i0] !== mem_rd(32'h200)) begin bad++; $display("FAIL flush_new_rdata got=%h required=%h", i_data[i0], mem_rd(32'h200)); end
    total++; if (i_cyc[i0] !== k + 9) begin bad++; $display("FAIL flush_new_ready_cycle got=%0d required=%0d", i_cyc[i0], k + 9); end

    // Flush of a fetch that is still only pending: it must never reach the bus.
    g0 = g_n; i0 = i_n;
    u_if.imem_valid = 1; u_if.imem_addr = 32'h1A0;
    step();
    u_if.imem_valid = 0; u_if.imem_flush = 1;
    step();
    u_if.imem_flush = 0;
    wait_idle(50);
    total++; if (g_n - g0 !== 0) begin bad++; $display("FAIL flush_pending_grants got=%0d required=0", g_n - g0); end
    total++; if (i_n - i0 !== 0) begin bad++; $display("FAIL flush_pending_ready got=%0d required=0", i_n - i0); end

    // Flush while the data side is being granted leaves the data side alone.
    lat = 1; g0 = g_n; i0 = i_n; d0 = d_n;
    u_if.imem_valid = 1; u_if.imem_addr = 32'h1C0;
    u_if.dmem_valid = 1; u_if.dmem_addr = 32'h2010;
    step();
    u_if.imem_valid = 0; u_if.dmem_valid = 0; u_if.imem_flush = 1;
    step();
    u_if.imem_flush = 0;
    wait_idle(50);
    total++; if (g_n - g0 !== 1) begin bad++; $display("FAIL flush_data_grants got=%0d required=1", g_n - g0); end
    total++; if ({g_instr[g0], g_addr[g0]} !== {1'b0, 32'h2010}) begin bad++; $display("FAIL flush_data_grant got=%b/%h required=0/00002010", g_instr[g0], g_addr[g0]); end
    total++; if (d_n - d0 !== 1) begin bad++; $display("FAIL flush_data_ready got=%0d required=1", d_n - d0); end
    total++; if (d_data[d0] !== mem_rd(32'h2010)) begin bad++; $display("FAIL flush_data_rdata got=%h required=%h", d_data[d0], mem_rd(32'h2010)); end
    total++; if (i_n - i0 !== 0) begin bad++; $display("FAIL flush_data_fetch_ready got=%0d required=0", i_n - i0); end
  endtask

  task automatic test_async_reset();
    int k, g0, i0, d0;
    lat = 3; g0 = g_n; d0 = d_n;
    u_if.dmem_valid = 1; u_if.dmem_addr = 32'h2020;
    step();
    u_if.dmem_valid = 0;
    step();
    total++; if (u_if.bus_valid !== 1'b1) begin bad++; $display("FAIL areset_busy got=%b required=1", u_if.bus_valid); end
    #4;
    rst = 1'b0;
    #1;
    total++; if (u_if.bus_valid !== 1'b0) begin bad++; $display("FAIL areset_bus_valid got=%b required=0", u_if.bus_valid); end
    total++; if (u_if.bus_addr !== 32'd0) begin bad++; $display("FAIL areset_bus_addr got=%h required=0", u_if.bus_addr); end
    step(); step();
    rst = 1'b1;
    for (int n = 0; n < 6; n++) step();
    total++; if (d_n - d0 !== 0) begin bad++; $display("FAIL areset_no_dready got=%0d required=0", d_n - d0); end
    total++; if (g_n - g0 !== 1) begin bad++; $display("FAIL areset_no_regrant got=%0d required=1", g_n - g0); end
    lat = 0; g0 = g_n; i0 = i_n; k = cyc;
    u_if.imem_valid = 1; u_if.imem_addr = 32'h240;
    step();
    u_if.imem_valid = 0;
    wait_idle(50);
    total++; if (g_cyc[g0] !== k + 2) begin bad++; $display("FAIL areset_idle_grant_cycle got=%0d required=%0d", g_cyc[g0], k + 2); end
    total++; if (i_n - i0 !== 1) begin bad++; $display("FAIL areset_fetch_ready got=%0d required=1", i_n - i0); end
    total++; if (i_data[i0] !== mem_rd(32'h240)) begin bad++; $display("FAIL areset_fetch_rdata got=%h required=%h", i_data[i0], mem_rd(32'h240)); end
  endtask

  task automatic test_back_to_back();
    int g0, i0, d0, idx, n;
    logic free_i, free_d;
    logic [31:0] a;
    lat = 0; g0 = g_n; i0 = i_n; d0 = d_n;
    idx = 0; free_i = 1'b1; free_d = 1'b1;
    for (n = 0; n < 200 && !(idx == 8 && free_i && free_d); n++) begin
      if (u_if.imem_ready) free_i = 1'b1;
      if (u_if.dmem_ready) free_d = 1'b1;
      if (idx < 8 && idx % 2 == 0 && free_i) begin
        u_if.imem_valid = 1; u_if.imem_addr = 32'h400 + 32'(16 * idx); free_i = 1'b0; idx++;
      end
      if (idx < 8 && idx % 2 == 1 && free_d) begin
        u_if.dmem_valid = 1; u_if.dmem_addr = 32'h3000 + 32'(16 * idx); u_if.dmem_wstrb = 4'h0; free_d = 1'b0; idx++;
      end
      step();
      u_if.imem_valid = 0; u_if.dmem_valid = 0;
    end
    total++; if (n >= 200) begin bad++; $display("FAIL b2b_timeout got=%0d issued required=8 completed", idx); end
    wait_idle(50);
    total++; if (g_n - g0 !== 8) begin bad++; $display("FAIL b2b_grants got=%0d required=8", g_n - g0); end
    total++; if (i_n - i0 !== 4) begin bad++; $display("FAIL b2b_imem_ready_cycles got=%0d required=4", i_n - i0); end
    total++; if (d_n - d0 !== 4) begin bad++; $display("FAIL b2b_dmem_ready_cycles got=%0d required=4", d_n - d0); end
    for (int m = 0; m < 4; m++) begin
      a = 32'h400 + 32'(32 * m);
      total++; if (i_data[i0+m] !== mem_rd(a)) begin bad++; $display("FAIL b2b_imem_rdata[%0d] got=%h required=%h", m, i_data[i0+m], mem_rd(a)); end
      a = 32'h3000 + 32'(32 * m + 16);
      total++; if (d_data[d0+m] !== mem_rd(a)) begin bad++; $display("FAIL b2b_dmem_rdata[%0d] got=%h required=%h", m, d_data[d0+m], mem_rd(a)); end
    end
    total++; if (stab_err !== 0) begin bad++; $display("FAIL bus_stable_while_busy got=%0d changes required=0", stab_err); end
    total++; if (viol !== 0) begin bad++; $display("FAIL requester_protocol got=%0d violations required=0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
